// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - serializing UART transmitter, one bit per clock: start, data LSB first, optional parity, stop
module uart_tx_frame #(
    parameter int WIDTH = 8
) (
    input  logic             Uart_Tx_CLK,
    input  logic             Uart_Tx_RST,
    input  logic [WIDTH-1:0] Uart_Tx_P_DATA,
    input  logic             Uart_Tx_Data_Valid,
    input  logic             Uart_Tx_PAR_EN,
    input  logic             Uart_Tx_PAR_TYP,
    output logic             Uart_Tx_OUT,
    output logic             Uart_Tx_Busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] data_reg;
    logic             par_en_reg;
    logic             par_typ_reg;

    logic [CW-1:0]    next_cnt;
    logic             parity_bit;

    assign next_cnt   = bit_cnt + 1'b1;
    assign parity_bit = (^data_reg) ^ par_typ_reg;

    // Outputs are registered alongside the state, so each branch loads the
    // line value that belongs to the state being entered.
    always_ff @(posedge Uart_Tx_CLK) begin
        if (Uart_Tx_RST) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            data_reg     <= '0;
            par_en_reg   <= 1'b0;
            par_typ_reg  <= 1'b0;
            Uart_Tx_OUT  <= 1'b1;
            Uart_Tx_Busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Uart_Tx_Data_Valid) begin
                        data_reg     <= Uart_Tx_P_DATA;
                        par_en_reg   <= Uart_Tx_PAR_EN;
                        par_typ_reg  <= Uart_Tx_PAR_TYP;
                        state        <= START;
                        Uart_Tx_OUT  <= 1'b0;
                        Uart_Tx_Busy <= 1'b1;
                    end else begin
                        Uart_Tx_OUT  <= 1'b1;
                        Uart_Tx_Busy <= 1'b0;
                    end
                end
                START: begin
                    state        <= DATA;
                    bit_cnt      <= '0;
                    Uart_Tx_OUT  <= data_reg[0];
                    Uart_Tx_Busy <= 1'b1;
                end
                DATA: begin
                    Uart_Tx_Busy <= 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        if (par_en_reg) begin
                            state       <= PARITY;
                            Uart_Tx_OUT <= parity_bit;
                        end else begin
                            state       <= STOP;
                            Uart_Tx_OUT <= 1'b1;
                        end
                    end else begin
                        bit_cnt     <= next_cnt;
                        Uart_Tx_OUT <= data_reg[next_cnt];
                    end
                end
                PARITY: begin
                    state        <= STOP;
                    Uart_Tx_OUT  <= 1'b1;
                    Uart_Tx_Busy <= 1'b1;
                end
                STOP: begin
                    // A request here chains straight into the next start bit.
                    if (Uart_Tx_Data_Valid) begin
                        data_reg     <= Uart_Tx_P_DATA;
                        par_en_reg   <= Uart_Tx_PAR_EN;
                        par_typ_reg  <= Uart_Tx_PAR_TYP;
                        state        <= START;
                        Uart_Tx_OUT  <= 1'b0;
                        Uart_Tx_Busy <= 1'b1;
                    end else begin
                        state        <= IDLE;
                        Uart_Tx_OUT  <= 1'b1;
                        Uart_Tx_Busy <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    Uart_Tx_OUT  <= 1'b1;
                    Uart_Tx_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
